// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
//   Shared types and constants for the four-requester round-robin mux arbiter.
//   - arb_state_t : arbiter FSM state (IDLE / GRANT)
//   - req_idx_t   : requester index, also the mux select pair {s1,s0}
//   - NUM_REQ     : number of requesters sharing the mux
//   - idx_onehot  : index -> one-hot grant vector
package mux_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [1:0] req_idx_t;

  function automatic logic [NUM_REQ-1:0] idx_onehot(req_idx_t idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_cell.sv
// mux4_cell
//   Plain 4:1 one-bit multiplexer cell.
//   Ports:
//     i0..i3 : data inputs
//     s0, s1 : select LSB / MSB, y = i[{s1,s0}]
//     y      : selected bit
module mux4_cell (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic y
);

  assign y = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin winner search. The search starts at ptr+1 and
//   wraps upward through all four indices; an index can optionally be removed
//   from the candidate set (used to skip the current owner on handoff).
//   Ports:
//     req         : request vector
//     ptr         : last released index; it gets lowest priority
//     exclude_en  : when 1, exclude_idx is not a candidate
//     exclude_idx : index to exclude
//     any         : at least one eligible request exists
//     winner      : eligible index found first in rotation order
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  input  logic               exclude_en,
  input  req_idx_t           exclude_idx,
  output logic               any,
  output req_idx_t           winner
);

  req_idx_t idx;

  always_comb begin
    any    = 1'b0;
    winner = ptr;
    idx    = '0;
    // Offsets 1..4 visit ptr+1 .. ptr (the 2-bit add wraps naturally), so
    // ptr itself is tried last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ptr + req_idx_t'(i);
      if (!any && req[idx] && !(exclude_en && (idx == exclude_idx))) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter sharing one 4:1 one-bit mux among four requesters.
//   The owner keeps the grant while it requests; after MAX_HOLD consecutive
//   cycles it is forced to hand off, but only if someone else is waiting.
//   Ports:
//     clk          : clock, rising edge
//     reset_n      : synchronous active-low reset
//     req          : request per requester
//     data_in      : one data bit per requester (mux inputs i0..i3)
//     gnt          : registered one-hot grant, zero when idle
//     s0, s1       : registered mux select = owner index
//     valid        : high exactly while a grant is active (gnt != 0)
//     data_out     : data_in[{s1,s0}] while valid, else 0
//     dbg_state    : FSM state, for observation
//     dbg_hold_cnt : consecutive-grant counter of the current owner
//     dbg_ptr      : index of the last released owner
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          data_in,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        s0,
  output logic                        s1,
  output logic                        valid,
  output logic                        data_out,
  output arb_state_t                  dbg_state,
  output logic [$clog2(MAX_HOLD)-1:0] dbg_hold_cnt,
  output req_idx_t                    dbg_ptr
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t         state_q, state_d;
  req_idx_t           sel_q, sel_d;
  req_idx_t           ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic     pick_any;
  req_idx_t pick_winner;
  req_idx_t pick_ptr;
  logic     in_grant;
  logic     mux_y;

  assign in_grant = (state_q == GRANT);
  // While granting, the search rotates from the owner and skips it, so a
  // handoff always moves to a different requester; when idle it rotates from
  // the last released owner.
  assign pick_ptr = in_grant ? sel_q : ptr_q;

  rr_pick u_pick (
    .req         (req),
    .ptr         (pick_ptr),
    .exclude_en  (in_grant),
    .exclude_idx (sel_q),
    .any         (pick_any),
    .winner      (pick_winner)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_winner;
          gnt_d   = idx_onehot(pick_winner);
          hold_d  = '0;
        end else begin
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          // Owner dropped: hand off in the same edge or go idle.
          ptr_d  = sel_q;
          hold_d = '0;
          if (pick_any) begin
            sel_d = pick_winner;
            gnt_d = idx_onehot(pick_winner);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (hold_q == HOLD_LAST) begin
          // At the limit: rotate only under contention, otherwise the
          // counter simply stays saturated.
          if (pick_any) begin
            ptr_d  = sel_q;
            sel_d  = pick_winner;
            gnt_d  = idx_onehot(pick_winner);
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= req_idx_t'(NUM_REQ - 1);
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  mux4_cell u_mux (
    .i0 (data_in[0]),
    .i1 (data_in[1]),
    .i2 (data_in[2]),
    .i3 (data_in[3]),
    .s0 (sel_q[0]),
    .s1 (sel_q[1]),
    .y  (mux_y)
  );

  assign gnt          = gnt_q;
  assign s0           = sel_q[0];
  assign s1           = sel_q[1];
  assign valid        = in_grant;
  assign data_out     = mux_y & in_grant;
  assign dbg_state    = state_q;
  assign dbg_hold_cnt = hold_q;
  assign dbg_ptr      = ptr_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int MAX_HOLD = 4;
  localparam int HW = $clog2(MAX_HOLD);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic [3:0]    req     = '0;
  logic [3:0]    data_in = '0;
  logic [3:0]    gnt;
  logic          s0, s1, valid, data_out;
  arb_state_t    dbg_state;
  logic [HW-1:0] dbg_hold_cnt;
  req_idx_t      dbg_ptr;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .data_in      (data_in),
    .gnt          (gnt),
    .s0           (s0),
    .s1           (s1),
    .valid        (valid),
    .data_out     (data_out),
    .dbg_state    (dbg_state),
    .dbg_hold_cnt (dbg_hold_cnt),
    .dbg_ptr      (dbg_ptr)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // busy/owner/held/last describe who owns the mux, how many cycles beyond
  // the first it has held it (capped), and who released most recently.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_held  = 0;
  int m_last  = 3;

  function automatic int rr_search(logic [3:0] r, int from);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (from + i) % 4;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [3:0] r, input logic rst);
    logic [3:0] others;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_held = 0; m_last = 3;
    end else if (!m_busy) begin
      if (r != 4'b0000) begin
        m_owner = rr_search(r, m_last);
        m_busy  = 1'b1;
        m_held  = 0;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] || (m_held >= MAX_HOLD - 1 && others != 4'b0000)) begin
        m_last = m_owner;
        m_held = 0;
        if (others != 4'b0000) m_owner = rr_search(others, m_owner);
        else m_busy = 1'b0;
      end else if (m_held < MAX_HOLD - 1) begin
        m_held = m_held + 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [3:0] e_gnt;
    e_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt",      32'(gnt),            32'(e_gnt));
    check("valid",    32'(valid),          32'(m_busy));
    check("sel",      32'({s1, s0}),       32'(m_owner));
    check("data_out", 32'(data_out),       32'(m_busy && data_in[m_owner]));
    check("hold_cnt", 32'(dbg_hold_cnt),   32'(m_held));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rst);
    @(negedge clk);
    req     = r;
    data_in = d;
    reset_n = !rst;
    @(posedge clk);
    model_update(r, rst);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] r;

    // 1: reset held with no requests
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b1111, 1'b1);
      check("t1_gnt", 32'(gnt), 32'h0);
      check("t1_dout", 32'(data_out), 32'h0);
    end

    // 2: single requester 2
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 4'b0100, 1'b0);
      check("t2_gnt", 32'(gnt), 32'h4);
      check("t2_sel", 32'({s1, s0}), 32'h2);
      check("t2_dout", 32'(data_out), 32'h1);
    end
    step(4'b0000, 4'b0100, 1'b0);
    check("t2_idle", 32'({gnt, valid, data_out}), 32'h0);

    // 3: full contention rotates 0,1,2,3,0 every MAX_HOLD cycles
    step(4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(4'b1111, 4'($urandom_range(0, 15)), 1'b0);
      check("t3_order", 32'(gnt), 32'(4'b0001 << ((k / MAX_HOLD) % 4)));
      check("t3_valid", 32'(valid), 32'h1);
    end

    // 4: uncontended owner saturates, then loses to a late requester
    step(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0001, 4'b0001, 1'b0);
    check("t4_gnt", 32'(gnt), 32'h1);
    check("t4_sat", 32'(dbg_hold_cnt), 32'(MAX_HOLD - 1));
    step(4'b0101, 4'b0100, 1'b0);
    check("t4_rot", 32'(gnt), 32'h4);

    // 5: owner 1 drops while 3 waits -> immediate handoff
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 1'b0);
    check("t5_own1", 32'(gnt), 32'h2);
    step(4'b1000, 4'b1000, 1'b0);
    check("t5_hand", 32'(gnt), 32'h8);
    // owner 1 releasing to idle leaves it last, so 0101 picks requester 2
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    check("t5_idle", 32'(valid), 32'h0);
    step(4'b0101, 4'b0000, 1'b0);
    check("t5_ptr", 32'(gnt), 32'h4);

    // 6: reset in the middle of a grant
    step(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1000, 4'b1000, 1'b0);
    check("t6_pre", 32'({gnt, dbg_hold_cnt}), 32'({4'b1000, HW'(2)}));
    step(4'b1000, 4'b1000, 1'b1);
    check("t6_rst", 32'({gnt, valid, s1, s0}), 32'h0);
    step(4'b1001, 4'b1001, 1'b0);
    check("t6_first", 32'(gnt), 32'h1);

    // randomized traffic; requests tend to persist so holds and timeouts occur
    r = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
      step(r, 4'($urandom_range(0, 15)), ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 one-bit mux datapath among four requesters. It registers a one-hot grant and drives the mux select pair (s1,s0) from the owner index. It holds ownership while the owner keeps requesting, up to MAX_HOLD cycles, and forces rotation only when another requester is waiting. It sits between the requester logic and the shared mux; data_out is the muxed bit of the current owner.

Parameters:
MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation when contended; legal range 2..16.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req  input  4  request per requester; bit k = requester k
data_in  input  4  one data bit per requester; drives mux inputs i0..i3
gnt  output  4  registered one-hot grant; all zero when idle
s0  output  1  mux select LSB = owner index bit 0
s1  output  1  mux select MSB = owner index bit 1
valid  output  1  high while a grant is active
data_out  output  1  data_in[{s1,s0}] when valid, else 0

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, gnt=0000, {s1,s0}=00, valid=0, hold_cnt=0, ptr=3. With ptr=3, requester 0 has first priority.
- Priority search: starts at (ptr+1) mod 4 and wraps upward; ptr = index of the last released owner.
- FSM states: IDLE, GRANT.
- IDLE -> GRANT: when any req bit is 1.
  - Winner is registered at the same edge.
  - gnt/valid/sel go high one cycle after req is first sampled.
  - hold_cnt=0.
- IDLE with req=0000: stay; {s1,s0} hold their last value; gnt=0, valid=0.
- GRANT, owner o, each edge:
  - Release-drop: req[o]=0. ptr<=o. If any other req is high, grant the next winner at this same edge, back-to-back with no idle cycle and hold_cnt=0. Otherwise go to IDLE, gnt=0, valid=0.
  - Release-timeout: hold_cnt==MAX_HOLD-1, req[o]=1, and any req[k≠o]=1. ptr<=o. Next winner is searched from o+1, excluding o. Handoff is back-to-back.
  - Uncontended at limit: hold_cnt==MAX_HOLD-1 and no other req. Keep owner; hold_cnt saturates at MAX_HOLD-1. If contention appears later, release at the next edge.
  - Otherwise: keep owner; hold_cnt<=hold_cnt+1.
- hold_cnt width: $clog2(MAX_HOLD) bits. It never wraps.
- gnt is always one-hot or zero; gnt[k]=1 implies {s1,s0}==k and valid=1.
- data_out is combinational from the registered select and data_in. It is 0 when valid=0.
- Simultaneous requests: resolved only by ptr order, never by index alone.
- A requester raising req in the same cycle as a release is eligible for that handoff.
- Reset mid-grant: at the reset edge all outputs take reset values regardless of req. Arbitration restarts with requester 0 highest priority.
- Latency: req to gnt is 1 cycle. Owner release to next gnt is 0 extra cycles.

Decomposition:
- Shared package mux_arb_pkg contains:
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - typedef logic [1:0] req_idx_t
  - constant NUM_REQ=4
- Sub-module rr_pick: combinational.
  - Inputs: req[3:0], ptr[1:0], exclude_en, exclude_idx.
  - Outputs: any, winner[1:0].
  - Used by both IDLE entry and handoff logic.
- The shared data path instantiates the team's existing 4:1 mux cell, driven by data_in, s0, s1. Its output is gated with valid to form data_out.

Test Plan:
1. Reset, req=0000 for 5 cycles -> gnt=0000, valid=0, {s1,s0}=00, data_out=0 throughout.
2. After reset, req=0100 held 3 cycles then 0000; data_in=0100 -> gnt=0100 from cycle 2 for 3 cycles, s1s0=10, data_out=1; then gnt=0000, valid=0.
3. req=1111 held continuously, MAX_HOLD=4 -> grant order 0,1,2,3,0. Each owner holds exactly 4 cycles; handoffs are back-to-back with valid never low.
4. req=0001 held for 10 cycles alone -> gnt=0001 for all 10, hold_cnt saturates at 3. req[2] then rises -> gnt=0100 on the following edge.
5. Owner 1 drops req while req[3]=1 -> gnt changes 0010 to 1000 at the very next edge. ptr=1, so a later simultaneous req=0101 grants requester 2.
6. reset_n=0 for one edge mid-grant (gnt=1000, hold_cnt=2) -> next cycle gnt=0000, valid=0, s1s0=00. With req=1001 afterwards, requester 0 wins first.
